// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
// Ports: clk; rst clears only the read register; we/waddr/wdata write port;
//        re/raddr load rdata on the next edge, rdata holds otherwise.
module sdp_ram #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: single-clock first-word-fall-through FIFO with occupancy count
// Ports: clk; rst async active-high; din/wr_en write side; rd_en pops the head;
//        dout head word (valid while empty=0); full/empty flags; data_count occupancy.
module sync_fwft_fifo #(
  parameter int WIDTH = 144,
  parameter int DEPTH = 256,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] data_count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wptr, rptr;
  logic valid, wr, rd, load;
  assign full  = data_count == CNT_W'(DEPTH);
  assign empty = !valid;
  assign wr    = wr_en & !full;
  assign rd    = rd_en & valid;
  // RAM holds a word not yet in the output stage whenever the count exceeds
  // what the output stage itself accounts for; pointer equality is ambiguous at full.
  assign load  = (data_count > CNT_W'(valid)) & (!valid | rd);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      valid      <= 1'b0;
      data_count <= '0;
    end else begin
      wptr       <= wptr + AW'(wr);
      rptr       <= rptr + AW'(load);
      valid      <= load | (valid & !rd);
      data_count <= data_count + CNT_W'(wr) - CNT_W'(rd);
    end
  // The RAM read register doubles as the FWFT output stage.
  sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr),
    .waddr (wptr),
    .wdata (din),
    .re    (load),
    .raddr (rptr),
    .rdata (dout)
  );
endmodule

// File: tb/tb_sync_fwft_fifo.sv
// tb_sync_fwft_fifo: self-checking bench for sync_fwft_fifo with a queue-based reference model
module tb_sync_fwft_fifo;
  localparam int WIDTH = 144;
  localparam int DEPTH = 256;
  localparam int CNT_W = 9;
  logic clk = 1'b0, rst = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0, dout;
  logic full, empty;
  logic [CNT_W-1:0] data_count;
  int n_cmp = 0, n_bad = 0;
  sync_fwft_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .full(full), .empty(empty), .data_count(data_count)
  );
  always #5 clk = ~clk;
  // Model: a queue of accepted words tagged with the edge that wrote them.
  // The head is on dout only once at least one later edge has passed.
  logic [WIDTH-1:0] qd [$];
  int qt [$];
  int e = 0;
  bit pres, fl;
  logic [WIDTH-1:0] mdout = '0;
  always @(posedge clk or posedge rst)
    if (rst) begin
      qd.delete();
      qt.delete();
      e = 0;
      mdout = '0;
    end else begin
      pres = qd.size() > 0 && qt[0] < e;
      fl = qd.size() == DEPTH;
      if (rd_en && pres) begin
        void'(qd.pop_front());
        void'(qt.pop_front());
      end
      if (wr_en && !fl) begin
        qd.push_back(din);
        qt.push_back(e + 1);
      end
      e++;
      if (qd.size() > 0 && qt[0] < e) mdout = qd[0];
    end
  task automatic chk(string n, logic [WIDTH-1:0] a, logic [WIDTH-1:0] x);
    n_cmp++;
    if (a !== x) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, x);
    end
  endtask
  always @(negedge clk)
    if (!rst) begin
      chk("model_empty", WIDTH'(empty), WIDTH'(!(qd.size() > 0 && qt[0] < e)));
      chk("model_full", WIDTH'(full), WIDTH'(qd.size() == DEPTH));
      chk("model_count", WIDTH'(data_count), WIDTH'(qd.size()));
      chk("model_dout", dout, mdout);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [WIDTH-1:0] a5;
  initial begin
    a5 = {18{8'hA5}};
    #1 rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_empty", WIDTH'(empty), 1);
    chk("rst_full", WIDTH'(full), 0);
    chk("rst_count", WIDTH'(data_count), 0);
    chk("rst_dout", dout, 0);
    wr_en = 1'b1; din = a5;
    step();
    wr_en = 1'b0;
    chk("a5_count_n", WIDTH'(data_count), 1);
    chk("a5_empty_n", WIDTH'(empty), 1);
    step();
    chk("a5_empty_n1", WIDTH'(empty), 0);
    chk("a5_dout_n1", dout, a5);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("a5_pop_empty", WIDTH'(empty), 1);
    chk("a5_pop_count", WIDTH'(data_count), 0);
    wr_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      din = WIDTH'(i);
      step();
    end
    chk("fill_full", WIDTH'(full), 1);
    chk("fill_count", WIDTH'(data_count), 256);
    din = WIDTH'(999);
    step();
    chk("ovf_count", WIDTH'(data_count), 256);
    chk("ovf_head", dout, 0);
    rd_en = 1'b1; din = WIDTH'(777);
    step();
    wr_en = 1'b0;
    chk("full_wr_rd_count", WIDTH'(data_count), 255);
    chk("full_deassert", WIDTH'(full), 0);
    for (int i = 1; i < DEPTH; i++) begin
      chk("drain_seq", dout, WIDTH'(i));
      step();
    end
    rd_en = 1'b0;
    chk("drain_empty", WIDTH'(empty), 1);
    chk("drain_count", WIDTH'(data_count), 0);
    wr_en = 1'b1;
    for (int i = 0; i < 241; i++) begin
      din = WIDTH'(i + 4096);
      step();
    end
    wr_en = 1'b0;
    chk("bp_count_241", WIDTH'(data_count), 241);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("bp_count_240", WIDTH'(data_count), 240);
    rd_en = 1'b1;
    for (int i = 0; i < 400 && data_count != 0; i++) step();
    rd_en = 1'b0;
    step();
    chk("bp_drained", WIDTH'(empty), 1);
    wr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      din = WIDTH'(i);
      step();
    end
    rd_en = 1'b1;
    for (int i = 2; i < 1002; i++) begin
      din = WIDTH'(i);
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("stream_count", WIDTH'(data_count), 2);
    chk("stream_head", dout, WIDTH'(1000));
    rd_en = 1'b1;
    for (int i = 0; i < 10 && data_count != 0; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rd_empty_count", WIDTH'(data_count), 0);
      chk("rd_empty_flag", WIDTH'(empty), 1);
      chk("rd_empty_dout", dout, WIDTH'(1001));
    end
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din = WIDTH'(i + 300);
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk("arst_empty", WIDTH'(empty), 1);
    chk("arst_full", WIDTH'(full), 0);
    chk("arst_count", WIDTH'(data_count), 0);
    chk("arst_dout", dout, 0);
    wr_en = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_empty", WIDTH'(empty), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
